event_param_gen: RTL and testbench
==================================

// Module: event_param_gen
// PURPOSE
//  Upstream neighbour of the state processor. Turns per-packet metadata into three
//  event parameters (length, per-port inter-arrival, flags/port word). Buffers them in
//  an 8-entry FWFT FIFO. The state processor pops one entry per action it consumes
//  (ev_rd_en tied to action_fifo_rd_en) and feeds the entry to event_param_in_1..3.
// PARAMETERS
//  PKT_SIZE_WIDTH  12  bits of packet size on pkt_size
//  TS_WIDTH        32  timestamp counter width; must equal `EVENT_PARAM_WIDTH
//  NUM_PORTS        8  per-port timestamp slots; power of two; index = src_port[log2(NUM_PORTS)-1:0]
//  DEPTH_BITS       3  event FIFO depth = 2**DEPTH_BITS
// PORTS
//  clk               in   1   clock
//  reset             in   1   asynchronous, active-high reset
//  pkt_info_vld      in   1   one-cycle strobe, metadata valid
//  pkt_size          in   PKT_SIZE_WIDTH  packet length in bytes
//  tcp_flags         in   8   TCP flags byte (0 for non-TCP)
//  src_port          in   `OPENFLOW_ENTRY_SRC_PORT_WIDTH  ingress port number
//  table_flush       in   1   watchdog flush; clears per-port history
//  ev_rd_en          in   1   pop head entry; ignored when ev_fifo_empty
//  event_param_out_1 out  `EVENT_PARAM_WIDTH  head: length param
//  event_param_out_2 out  `EVENT_PARAM_WIDTH  head: inter-arrival param
//  event_param_out_3 out  `EVENT_PARAM_WIDTH  head: flags/port param
//  ev_fifo_empty     out  1   FIFO empty
//  ev_fifo_full      out  1   FIFO full
//  drop_cnt          out  16  entries lost to a full FIFO, saturating
// BEHAVIOUR
//  - Reset: FIFO empty (ev_fifo_empty=1, ev_fifo_full=0), params=0, drop_cnt=0,
//    ts=0, all port valid bits=0, pipeline valid=0.
//  - ts: free-running TS_WIDTH counter, +1 every cycle, wraps 2**TS_WIDTH-1 -> 0.
//  - Stage 1 (cycle N+1, from pkt_info_vld at N). Index p = low bits of src_port.
//    - P1 = zero-extended pkt_size.
//    - P2 = valid[p] ? (ts_N - last[p]) mod 2**TS_WIDTH : all-ones.
//      Modular subtract handles ts wrap.
//    - P3 = {tcp_flags, src_port[7:0], 16'h0}.
//    - last[p] <= ts_N; valid[p] <= 1.
//  - Stage 2 (cycle N+2): {P3,P2,P1} written to FIFO. ev_fifo_empty low at N+2.
//  - Back-to-back pkt_info_vld on the same port: the second sees the first's timestamp
//    (bypass of in-flight last[] write). Back-to-back on port 3 gives P2=1.
//  - FIFO is FWFT: outputs show the head whenever non-empty and hold the last value
//    when empty.
//  - ev_rd_en while empty: no effect.
//  - Write while full and no pop: entry discarded; drop_cnt+1, saturates at 16'hFFFF.
//  - Write and pop in the same cycle while full: both succeed; no drop.
//  - Write and pop while empty: the entry is written, the pop is ignored.
//  - Pointers wrap modulo 2**DEPTH_BITS. Full = count==2**DEPTH_BITS.
//  - table_flush: all valid bits and counters clear next cycle.
//    - The FIFO and drop_cnt are untouched.
//    - A stage-1 update in the same cycle loses to the flush.
//  - Reset mid-operation: everything returns to reset values immediately.
//    In-flight entries are lost and not counted as drops.
// CONFIGURATION
//  EVENT_PARAM_PKTCNT_EN defined:
//    - Per-port 16-bit packet counter, +1 on each packet, saturating at 16'hFFFF.
//    - P3[15:0] = the count including the current packet (first packet gives 1).
//  EVENT_PARAM_PKTCNT_EN undefined: no counters; P3[15:0] = 16'h0.
// TESTING
//  1 After reset, pkt(size=64, port=2, flags=8'h02) at ts=10 -> at N+2 head P1=64,
//    P2=32'hFFFFFFFF, P3=32'h0202_0000 (32'h0202_0001 with EVENT_PARAM_PKTCNT_EN).
//  2 Port 2 again at ts=110 -> P2=100. Port 2 strobes in consecutive cycles -> second P2=1.
//  3 last[5] at ts=32'hFFFFFFF0, next port-5 packet after ts wraps to 32'h10 -> P2=32'h20.
//  4 9 packets with ev_rd_en=0 -> full after 8, drop_cnt=1, head is still packet 1.
//    Then pop and write in the same cycle while full -> no drop, drop_cnt stays 1.
//  5 Pulse table_flush, then send a port-2 packet -> P2=all-ones, count restarts at 1.
//    drop_cnt and FIFO contents are unchanged.
//  6 Assert reset while 3 entries are queued -> empty=1, drop_cnt=0; the next packet
//    appears at N+2 with P2=all-ones.

Source files
------------

// File: rtl/event_param_gen.sv
// Turns per-packet metadata into three event parameters (length, per-port inter-arrival,
// flags/port word) queued in a FWFT FIFO. Optional per-port packet counters: EVENT_PARAM_PKTCNT_EN.
`ifndef EVENT_PARAM_WIDTH
`define EVENT_PARAM_WIDTH 32
`endif
`ifndef OPENFLOW_ENTRY_SRC_PORT_WIDTH
`define OPENFLOW_ENTRY_SRC_PORT_WIDTH 8
`endif

module event_param_gen #(
    parameter int PKT_SIZE_WIDTH = 12,
    parameter int TS_WIDTH       = 32,
    parameter int NUM_PORTS      = 8,
    parameter int DEPTH_BITS     = 3
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      pkt_info_vld,
    input  logic [PKT_SIZE_WIDTH-1:0]                 pkt_size,
    input  logic [7:0]                                tcp_flags,
    input  logic [`OPENFLOW_ENTRY_SRC_PORT_WIDTH-1:0] src_port,
    input  logic                                      table_flush,
    input  logic                                      ev_rd_en,
    output logic [`EVENT_PARAM_WIDTH-1:0]             event_param_out_1,
    output logic [`EVENT_PARAM_WIDTH-1:0]             event_param_out_2,
    output logic [`EVENT_PARAM_WIDTH-1:0]             event_param_out_3,
    output logic                                      ev_fifo_empty,
    output logic                                      ev_fifo_full,
    output logic [15:0]                               drop_cnt
);

    localparam int PW      = `EVENT_PARAM_WIDTH;
    localparam int IDX_W   = $clog2(NUM_PORTS);
    localparam int DEPTH   = 1 << DEPTH_BITS;
    localparam int ENTRY_W = 3 * PW;

    // Timestamp and per-port arrival history
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [TS_WIDTH-1:0]  last_q [NUM_PORTS];
    logic [TS_WIDTH-1:0]  last_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] valid_q, valid_d;
`ifdef EVENT_PARAM_PKTCNT_EN
    logic [15:0]          cnt_q [NUM_PORTS];
    logic [15:0]          cnt_d [NUM_PORTS];
    logic [15:0]          cnt_cur;
`endif

    // Stage-1 parameter registers
    logic          s1_vld_q, s1_vld_d;
    logic [PW-1:0] p1_q, p1_d;
    logic [PW-1:0] p2_q, p2_d;
    logic [PW-1:0] p3_q, p3_d;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [ENTRY_W-1:0]    hold_q, hold_d;
    logic [15:0]           drop_q, drop_d;

    logic [IDX_W-1:0]   port_idx;
    logic [7:0]         src_byte;
    logic [15:0]        pkt_tag;
    logic               fifo_empty, fifo_full, do_push, do_pop;
    logic [ENTRY_W-1:0] wr_data, head;

    always_comb begin
        ts_d     = ts_q + TS_WIDTH'(1);
        port_idx = src_port[IDX_W-1:0];
        src_byte = 8'(src_port);
        last_d   = last_q;
        valid_d  = valid_q;
        s1_vld_d = pkt_info_vld;
        p1_d     = p1_q;
        p2_d     = p2_q;
        p3_d     = p3_q;
`ifdef EVENT_PARAM_PKTCNT_EN
        cnt_d   = cnt_q;
        cnt_cur = (cnt_q[port_idx] == 16'hFFFF) ? 16'hFFFF : cnt_q[port_idx] + 16'd1;
        pkt_tag = cnt_cur;
        if (pkt_info_vld) cnt_d[port_idx] = cnt_cur;
        if (table_flush)  cnt_d = '{default: '0};
`else
        pkt_tag = 16'h0;
`endif
        if (pkt_info_vld) begin
            p1_d = PW'(pkt_size);
            // Modular subtraction keeps the gap correct across a timestamp wrap
            p2_d = valid_q[port_idx] ? PW'(ts_q - last_q[port_idx]) : '1;
            p3_d = PW'({tcp_flags, src_byte, pkt_tag});
            last_d[port_idx]  = ts_q;
            valid_d[port_idx] = 1'b1;
        end
        if (table_flush) valid_d = '0;
    end

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == (DEPTH_BITS+1)'(DEPTH));
        do_pop     = ev_rd_en && !fifo_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
        do_push    = s1_vld_q && (!fifo_full || do_pop);
        wr_data    = {p3_q, p2_q, p1_q};
        head       = fifo_empty ? hold_q : mem_q[rd_ptr_q];
        wr_ptr_d   = do_push ? wr_ptr_q + DEPTH_BITS'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + DEPTH_BITS'(1) : rd_ptr_q;
        hold_d     = do_pop  ? mem_q[rd_ptr_q] : hold_q;
        count_d    = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
            default: count_d = count_q;
        endcase
        drop_d = drop_q;
        if (s1_vld_q && !do_push && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            last_q   <= '{default: '0};
            valid_q  <= '0;
`ifdef EVENT_PARAM_PKTCNT_EN
            cnt_q    <= '{default: '0};
`endif
            s1_vld_q <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            drop_q   <= '0;
        end else begin
            ts_q     <= ts_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
`ifdef EVENT_PARAM_PKTCNT_EN
            cnt_q    <= cnt_d;
`endif
            s1_vld_q <= s1_vld_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: it is only read while the count says it is occupied
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign {event_param_out_3, event_param_out_2, event_param_out_1} = head;
    assign ev_fifo_empty = fifo_empty;
    assign ev_fifo_full  = fifo_full;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_event_param_gen.sv
// Scoreboard bench for event_param_gen: stimulus pushes expected FIFO entries, a monitor
// pops and compares them as the DUT presents them. Expected counts follow EVENT_PARAM_PKTCNT_EN.
module tb_event_param_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_info_vld = 1'b0;
    logic [11:0] pkt_size = '0;
    logic [7:0]  tcp_flags = '0;
    logic [7:0]  src_port = '0;
    logic        table_flush = 1'b0;
    logic        ev_rd_en = 1'b0;
    logic [31:0] event_param_out_1, event_param_out_2, event_param_out_3;
    logic        ev_fifo_empty, ev_fifo_full;
    logic [15:0] drop_cnt;
    logic [95:0] head;

    int n_checks = 0;
    int n_errors = 0;
    logic [95:0] exp_q[$];
    bit auto_pop = 1'b1;
    int pop_req = 0;
    int pop_done = 0;

    logic [31:0] tb_ts;
    logic        ts_jump = 1'b0;
    logic [31:0] jump_val = '0;

    event_param_gen dut (
        .clk(clk), .reset(reset), .pkt_info_vld(pkt_info_vld), .pkt_size(pkt_size),
        .tcp_flags(tcp_flags), .src_port(src_port), .table_flush(table_flush),
        .ev_rd_en(ev_rd_en), .event_param_out_1(event_param_out_1),
        .event_param_out_2(event_param_out_2), .event_param_out_3(event_param_out_3),
        .ev_fifo_empty(ev_fifo_empty), .ev_fifo_full(ev_fifo_full), .drop_cnt(drop_cnt)
    );

    assign head = {event_param_out_3, event_param_out_2, event_param_out_1};

    always #5 clk = ~clk;

    // Reference timestamp: counts cycles since reset, with an optional jump
    always @(posedge clk or posedge reset) begin
        if (reset)        tb_ts <= '0;
        else if (ts_jump) tb_ts <= jump_val;
        else              tb_ts <= tb_ts + 32'd1;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [11:0] size, input logic [7:0] port, input logic [7:0] flags,
                        input logic [31:0] p2, input logic [15:0] cnt, input bit push);
        logic [15:0] lo;
`ifdef EVENT_PARAM_PKTCNT_EN
        lo = cnt;
`else
        lo = 16'h0;
`endif
        if (push) exp_q.push_back({flags, port, lo, p2, 20'h0, size});
        pkt_info_vld = 1'b1;
        pkt_size     = size;
        src_port     = port;
        tcp_flags    = flags;
        @(negedge clk);
        pkt_info_vld = 1'b0;
    endtask

    task automatic wait_ts(input logic [31:0] target);
        for (int i = 0; i < 2000 && tb_ts != target; i++) @(negedge clk);
        if (tb_ts != target) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_ts: got %h expected %h", tb_ts, target);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk({name, "_left"}, 96'(exp_q.size()), 96'd0);
        chk({name, "_empty"}, 96'(ev_fifo_empty), 96'd1);
    endtask

    // Monitor: pops and checks the head whenever popping is enabled
    initial begin
        forever begin
            @(negedge clk);
            #2;
            ev_rd_en = 1'b0;
            if (!reset && !ev_fifo_empty && (auto_pop || pop_done < pop_req)) begin
                if (pop_done < pop_req) pop_done++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_entry: got %h expected none", head);
                end else begin
                    chk("head", head, exp_q.pop_front());
                end
                ev_rd_en = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [95:0] exp_first;
        repeat (3) @(negedge clk);
        chk("rst_empty_in", 96'(ev_fifo_empty), 96'd1);
        reset = 1'b0;
        chk("rst_empty", 96'(ev_fifo_empty), 96'd1);
        chk("rst_full", 96'(ev_fifo_full), 96'd0);
        chk("rst_params", head, 96'd0);
        chk("rst_drop", 96'(drop_cnt), 96'd0);

        // First packet on port 2 at ts=10, with latency check
        wait_ts(32'd10);
        send(12'd64, 8'd2, 8'h02, 32'hFFFF_FFFF, 16'd1, 1'b1);
        chk("lat_n1_empty", 96'(ev_fifo_empty), 96'd1);
        exp_first = exp_q[0];
        @(negedge clk);
        chk("lat_n2_empty", 96'(ev_fifo_empty), 96'd0);
        chk("lat_n2_head", head, exp_first);
        wait_drain("t1");

        // Gap of 100 cycles, then back-to-back on the same port
        wait_ts(32'd110);
        send(12'd128, 8'd2, 8'h10, 32'd100, 16'd2, 1'b1);
        send(12'd256, 8'd2, 8'h11, 32'd1, 16'd3, 1'b1);
        wait_drain("t2");

        // Timestamp wrap on port 5
        jump_val = 32'hFFFF_FFEF;
        ts_jump  = 1'b1;
        force dut.ts_d = 32'hFFFF_FFEF;
        @(posedge clk);
        #1;
        release dut.ts_d;
        ts_jump = 1'b0;
        @(negedge clk);
        wait_ts(32'hFFFF_FFF0);
        send(12'd1500, 8'd5, 8'h18, 32'hFFFF_FFFF, 16'd1, 1'b1);
        wait_ts(32'h10);
        send(12'd40, 8'd5, 8'h10, 32'h20, 16'd2, 1'b1);
        wait_drain("t3");

        // Fill with 9 back-to-back packets, no pops
        auto_pop = 1'b0;
        for (int i = 0; i < 9; i++)
            send(12'(100 + i), 8'd7, 8'h10, (i == 0) ? 32'hFFFF_FFFF : 32'd1, 16'(i + 1), i < 8);
        repeat (2) @(negedge clk);
        chk("fill_full", 96'(ev_fifo_full), 96'd1);
        chk("fill_drop", 96'(drop_cnt), 96'd1);
        chk("fill_head", head, exp_q[0]);
        // Write and pop land in the same cycle while full
        send(12'd200, 8'd6, 8'h18, 32'hFFFF_FFFF, 16'd1, 1'b1);
        pop_req++;
        repeat (2) @(negedge clk);
        chk("pushpop_drop", 96'(drop_cnt), 96'd1);
        chk("pushpop_full", 96'(ev_fifo_full), 96'd1);
        auto_pop = 1'b1;
        wait_drain("t4");
        chk("t4_drop", 96'(drop_cnt), 96'd1);

        // Flush clears history but leaves FIFO and drop count alone
        auto_pop = 1'b0;
        send(12'd300, 8'd1, 8'h00, 32'hFFFF_FFFF, 16'd1, 1'b1);
        repeat (2) @(negedge clk);
        table_flush = 1'b1;
        @(negedge clk);
        table_flush = 1'b0;
        chk("flush_empty", 96'(ev_fifo_empty), 96'd0);
        chk("flush_drop", 96'(drop_cnt), 96'd1);
        send(12'd400, 8'd2, 8'h02, 32'hFFFF_FFFF, 16'd1, 1'b1);
        repeat (2) @(negedge clk);
        auto_pop = 1'b1;
        wait_drain("t5");

        // Reset with entries queued
        auto_pop = 1'b0;
        send(12'd10, 8'd0, 8'h01, 32'hFFFF_FFFF, 16'd1, 1'b0);
        send(12'd11, 8'd3, 8'h01, 32'hFFFF_FFFF, 16'd1, 1'b0);
        send(12'd12, 8'd4, 8'h01, 32'hFFFF_FFFF, 16'd1, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_empty", 96'(ev_fifo_empty), 96'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_empty", 96'(ev_fifo_empty), 96'd1);
        chk("mid_rst_drop", 96'(drop_cnt), 96'd0);
        chk("mid_rst_full", 96'(ev_fifo_full), 96'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(12'd64, 8'd2, 8'h02, 32'hFFFF_FFFF, 16'd1, 1'b1);
        chk("t6_n1_empty", 96'(ev_fifo_empty), 96'd1);
        @(negedge clk);
        chk("t6_n2_empty", 96'(ev_fifo_empty), 96'd0);
        auto_pop = 1'b1;
        wait_drain("t6");
        chk("t6_drop", 96'(drop_cnt), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
